// File: rtl/dotl_arbiter.sv
// dotl_arbiter -- round-robin owner of a shared dice / traffic-light unit.
//
// Two level requesters (dice, traffic light) share one unit that has a mode
// select and a push button. A grant walks IDLE -> SETUP -> RUN -> CAPTURE ->
// DONE: SETUP lets the unit's mux settle with the button released, RUN holds
// the button for a mode-specific number of cycles, CAPTURE releases it and
// latches the unit result, and DONE pulses valid before releasing the grant.
//
// Ports
//   clk        rising-edge system clock
//   rst        asynchronous active-low reset
//   req_dice   level request for a dice roll
//   req_tl     level request for a traffic-light advance
//   result_in  3-bit result from the shared unit
//   sel        unit mode select (0 = dice, 1 = traffic lights)
//   button     unit button drive
//   gnt_dice   dice requester owns the unit
//   gnt_tl     traffic-light requester owns the unit
//   valid      one-cycle pulse, dout holds a completed result
//   dout       result captured at the end of the last grant
//   busy       high whenever the FSM is not in IDLE
//
// Parameters
//   DICE_RUN   button-high cycles for a dice grant (1..255, 0 acts as 1)
//   TL_RUN     button-high cycles for a traffic-light grant (1..255, 0 acts as 1)

module dotl_arbiter #(
  parameter int DICE_RUN = 8,
  parameter int TL_RUN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_dice,
  input  logic       req_tl,
  input  logic [2:0] result_in,
  output logic       sel,
  output logic       button,
  output logic       gnt_dice,
  output logic       gnt_tl,
  output logic       valid,
  output logic [2:0] dout,
  output logic       busy
);

  // Run lengths clamped into the 8-bit counter range; zero behaves as one.
  localparam logic [7:0] DICE_N = (DICE_RUN <= 0)   ? 8'd1   :
                                  (DICE_RUN >  255) ? 8'd255 : 8'(DICE_RUN);
  localparam logic [7:0] TL_N   = (TL_RUN   <= 0)   ? 8'd1   :
                                  (TL_RUN   >  255) ? 8'd255 : 8'(TL_RUN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       last_tl;   // 1: traffic light was served most recently
  logic       any_req;
  logic       pick_tl;

  // Traffic light wins when it is the only requester, or when both request
  // and dice was the one served last.
  assign any_req = req_dice | req_tl;
  assign pick_tl = req_tl & (~req_dice | ~last_tl);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      last_tl  <= 1'b1;
      sel      <= 1'b0;
      button   <= 1'b0;
      gnt_dice <= 1'b0;
      gnt_tl   <= 1'b0;
      valid    <= 1'b0;
      dout     <= 3'b000;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= SETUP;
            sel      <= pick_tl;
            gnt_tl   <= pick_tl;
            gnt_dice <= ~pick_tl;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          // Counter holds the remaining RUN cycles after the current one,
          // so RUN ends on the edge that sees zero.
          state  <= RUN;
          button <= 1'b1;
          cnt    <= sel ? (TL_N - 8'd1) : (DICE_N - 8'd1);
        end
        RUN: begin
          if (cnt == 8'd0) begin
            state  <= CAPTURE;
            button <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CAPTURE: begin
          state <= DONE;
          dout  <= result_in;
          valid <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          gnt_dice <= 1'b0;
          gnt_tl   <= 1'b0;
          busy     <= 1'b0;
          last_tl  <= sel;
        end
        default: begin
          state    <= IDLE;
          button   <= 1'b0;
          gnt_dice <= 1'b0;
          gnt_tl   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dotl_arbiter.sv
// Scoreboard bench for dotl_arbiter (DICE_RUN=8, TL_RUN=1). Stimulus pushes
// the expected sel/dout/button-length of each grant; a negedge monitor pops
// and compares on every valid pulse.

module tb_dotl_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_dice = 1'b0;
  logic       req_tl = 1'b0;
  logic [2:0] result_in = 3'b000;
  logic       sel, button, gnt_dice, gnt_tl, valid, busy;
  logic [2:0] dout;

  dotl_arbiter #(.DICE_RUN(8), .TL_RUN(1)) dut (
    .clk(clk), .rst(rst), .req_dice(req_dice), .req_tl(req_tl),
    .result_in(result_in), .sel(sel), .button(button),
    .gnt_dice(gnt_dice), .gnt_tl(gnt_tl), .valid(valid),
    .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [2:0] dout;
    int         nbtn;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   btn_run = 0;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  function automatic void push(logic s, logic [2:0] d, int n);
    exp_t e;
    e.sel = s; e.dout = d; e.nbtn = n;
    exp_q.push_back(e);
  endfunction

  // Monitor: button-high length and result check at each valid.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      btn_run = 0;
      if (valid) chk("valid_in_reset", 1, 0);
    end else begin
      if (button) btn_run++;
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_sel", int'(sel), int'(e.sel));
          chk("sb_dout", int'(dout), int'(e.dout));
          chk("sb_button_len", btn_run, e.nbtn);
          chk("sb_gnt", int'({gnt_dice, gnt_tl}), e.sel ? 1 : 2);
          chk("sb_busy", int'(busy), 1);
        end
        btn_run = 0;
      end
    end
  end

  task automatic chk_reset_outs(string tag);
    chk({tag, "_sel"},    int'(sel), 0);
    chk({tag, "_button"}, int'(button), 0);
    chk({tag, "_gnt"},    int'({gnt_dice, gnt_tl}), 0);
    chk({tag, "_valid"},  int'(valid), 0);
    chk({tag, "_dout"},   int'(dout), 0);
    chk({tag, "_busy"},   int'(busy), 0);
  endtask

  // Single requester: raise request at a negedge, drop it at negedge number
  // drop_at (or at valid if earlier), and measure negedges until valid.
  task automatic run_single(input logic is_tl, input logic [2:0] res,
                            input int drop_at, input int exp_lat,
                            input int nbtn, input string nm);
    int lat;
    logic seen;
    lat = 0;
    seen = 1'b0;
    result_in = res;
    push(is_tl, res, nbtn);
    if (is_tl) req_tl = 1'b1; else req_dice = 1'b1;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (valid) seen = 1'b1;
      if (lat >= drop_at || seen) begin
        req_tl = 1'b0;
        req_dice = 1'b0;
      end
    end
    if (!seen) chk({nm, "_timeout"}, lat, exp_lat);
    else chk({nm, "_latency"}, lat, exp_lat);
    req_tl = 1'b0;
    req_dice = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int nv, cyc, busy_seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Dice grant, one-cycle request pulse
    run_single(1'b0, 3'b100, 1, 11, 8, "dice");
    chk("dice_hold_dout", int'(dout), 4);
    chk("dice_idle_busy", int'(busy), 0);

    // Traffic-light grant, request held until valid
    run_single(1'b1, 3'b010, 99, 4, 1, "tl");

    // Idle hold after a tl grant
    busy_seen = 0;
    result_in = 3'b111;
    repeat (20) begin
      @(negedge clk);
      if (busy || button) busy_seen++;
    end
    chk("idle_busy_or_button", busy_seen, 0);
    chk("idle_sel", int'(sel), 1);
    chk("idle_dout", int'(dout), 2);
    chk("idle_gnt", int'({gnt_dice, gnt_tl}), 0);

    // Request dropped in RUN cycle 3
    run_single(1'b0, 3'b111, 4, 11, 8, "drop");
    chk("drop_dout", int'(dout), 7);

    // Both requests held from reset: dice, tl, dice, tl
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    result_in = 3'b101;
    push(1'b0, 3'b101, 8);
    push(1'b1, 3'b101, 1);
    push(1'b0, 3'b101, 8);
    push(1'b1, 3'b101, 1);
    req_dice = 1'b1;
    req_tl = 1'b1;
    nv = 0;
    cyc = 0;
    while (nv < 4 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (valid) nv++;
    end
    req_dice = 1'b0;
    req_tl = 1'b0;
    chk("rr_valids", nv, 4);
    repeat (3) @(negedge clk);

    // Reset in the middle of RUN
    result_in = 3'b110;
    req_dice = 1'b1;
    repeat (4) @(negedge clk);
    req_dice = 1'b0;
    chk("midrun_button_before", int'(button), 1);
    #2 rst = 1'b0;
    #1 chk_reset_outs("midrun");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fresh dice grant after reset release
    run_single(1'b0, 3'b001, 1, 11, 8, "post_reset");

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
